// File: rtl/gcm_ctr_gen_pkg.sv
// -----------------------------------------------------------------------------
// gcm_ctr_gen_pkg
// Shared constants and types for the GCM counter-block generator.
//   BLK_W      : cipher block width (IV || counter)
//   J0_CTR     : counter value appended to the IV to form the pre-counter block J0
//   FIRST_CTR  : first counter value handed out for payload blocks
//   ctx_t      : per-channel context layout at the default widths
// -----------------------------------------------------------------------------
package gcm_ctr_gen_pkg;

    localparam int unsigned BLK_W     = 128;
    localparam int unsigned DEF_CTR_W = 32;
    localparam int unsigned DEF_IV_W  = BLK_W - DEF_CTR_W;
    localparam int unsigned DEF_LEN_W = 32;

    localparam int unsigned J0_CTR    = 1;
    localparam int unsigned FIRST_CTR = 2;

    // One channel context: the IV is fixed for the instance, the counter field
    // advances per issued block, and 'remaining' bounds how many blocks may be drawn.
    typedef struct packed {
        logic                 active;
        logic [DEF_LEN_W-1:0] remaining;
        logic [DEF_CTR_W-1:0] ctr;
        logic [DEF_IV_W-1:0]  iv;
    } ctx_t;

endpackage

// File: rtl/gcm_ctr_ctx.sv
// -----------------------------------------------------------------------------
// gcm_ctr_ctx
// Storage and update logic for one counter context (one channel).
//   clk, rst_n     : clock, asynchronous active-low reset
//   i_load         : start a new instance (IV, counter preset, block budget)
//   i_iv           : instance IV
//   i_num_blocks   : block budget; zero leaves the context inactive
//   i_adv          : one block was issued from this context
//   o_iv, o_ctr    : current IV and counter field
//   o_active       : context still has blocks to hand out
//   o_last         : the next issued block consumes the final budget entry
// -----------------------------------------------------------------------------
module gcm_ctr_ctx
    import gcm_ctr_gen_pkg::*;
#(
    parameter int unsigned      IV_W     = DEF_IV_W,
    parameter int unsigned      CTR_W    = DEF_CTR_W,
    parameter int unsigned      LEN_W    = DEF_LEN_W,
    parameter logic [CTR_W-1:0] CTR_INIT = CTR_W'(FIRST_CTR)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [IV_W-1:0]  i_iv,
    input  logic [LEN_W-1:0] i_num_blocks,
    input  logic             i_adv,
    output logic [IV_W-1:0]  o_iv,
    output logic [CTR_W-1:0] o_ctr,
    output logic             o_active,
    output logic             o_last
);

    logic [IV_W-1:0]  r_iv;
    logic [CTR_W-1:0] r_ctr;
    logic [LEN_W-1:0] r_rem;
    logic             r_active;

    // NOTE: state registers use non-blocking assignments so every context
    // samples the same pre-edge values regardless of evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_iv     <= '0;
            r_ctr    <= '0;
            r_rem    <= '0;
            r_active <= 1'b0;
        end else if (i_load) begin
            // A load discards whatever instance was in flight on this channel.
            r_iv     <= i_iv;
            r_ctr    <= CTR_INIT;
            r_rem    <= i_num_blocks;
            r_active <= (i_num_blocks != '0);
        end else if (i_adv && r_active) begin
            // Counter wraps modulo 2^CTR_W; the IV field is never touched.
            r_ctr    <= r_ctr + CTR_W'(1);
            r_rem    <= r_rem - LEN_W'(1);
            r_active <= (r_rem != LEN_W'(1));
        end
    end

    assign o_iv     = r_iv;
    assign o_ctr    = r_ctr;
    assign o_active = r_active;
    assign o_last   = (r_rem == LEN_W'(1));

endmodule

// File: rtl/gcm_ctr_gen.sv
// -----------------------------------------------------------------------------
// gcm_ctr_gen
// Multi-channel GCM counter-block generator. Each channel is loaded with an IV
// and a block budget; requests then draw {IV, counter} blocks one per cycle.
//   clk, rst_n                       : clock, asynchronous active-low reset
//   i_load, i_load_ch, i_iv,
//   i_num_blocks                     : start a new instance on a channel
//   o_j0, o_j0_valid                 : pre-counter block {IV, 1}, one cycle after load
//   i_req_valid, i_req_ch,
//   o_req_ready                      : counter-block request handshake
//   o_cb_valid, o_cb, o_cb_ch,
//   o_cb_last, i_cb_ready            : counter-block output handshake
//   o_err                            : one-cycle pulse on a rejected request
// Parameters: NUM_CH channels, IV_W/CTR_W field widths, LEN_W budget width,
// CTR_INIT first payload counter (normally FIRST_CTR).
// -----------------------------------------------------------------------------
module gcm_ctr_gen
    import gcm_ctr_gen_pkg::*;
#(
    parameter int unsigned      NUM_CH   = 4,
    parameter int unsigned      IV_W     = DEF_IV_W,
    parameter int unsigned      CTR_W    = DEF_CTR_W,
    parameter int unsigned      LEN_W    = DEF_LEN_W,
    parameter logic [CTR_W-1:0] CTR_INIT = CTR_W'(FIRST_CTR),
    localparam int unsigned     CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int unsigned     BLK      = IV_W + CTR_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CH_W-1:0]  i_load_ch,
    input  logic [IV_W-1:0]  i_iv,
    input  logic [LEN_W-1:0] i_num_blocks,
    output logic [BLK-1:0]   o_j0,
    output logic             o_j0_valid,
    input  logic             i_req_valid,
    input  logic [CH_W-1:0]  i_req_ch,
    output logic             o_req_ready,
    output logic             o_cb_valid,
    output logic [BLK-1:0]   o_cb,
    output logic [CH_W-1:0]  o_cb_ch,
    output logic             o_cb_last,
    input  logic             i_cb_ready,
    output logic             o_err
);

    // Context views are padded to a power of two so any i_req_ch value indexes
    // safely; padding entries read as inactive.
    localparam int unsigned CH_N = 1 << CH_W;

    logic [IV_W-1:0]  w_iv     [CH_N];
    logic [CTR_W-1:0] w_ctr    [CH_N];
    logic [CH_N-1:0]  w_active;
    logic [CH_N-1:0]  w_last;

    logic w_flow;
    logic w_collide;
    logic w_req_ready;
    logic w_accept;
    logic w_issue;
    logic w_reject;

    logic             r_rdy_en;
    logic [BLK-1:0]   r_j0;
    logic             r_j0_valid;
    logic             r_cb_valid;
    logic [BLK-1:0]   r_cb;
    logic [CH_W-1:0]  r_cb_ch;
    logic             r_cb_last;
    logic             r_err;

    for (genvar g = 0; g < CH_N; g++) begin : g_ch
        if (g < NUM_CH) begin : g_ctx
            logic w_load;
            logic w_adv;

            assign w_load = i_load && (i_load_ch == CH_W'(g));
            assign w_adv  = w_issue && (i_req_ch == CH_W'(g));

            gcm_ctr_ctx #(
                .IV_W     (IV_W),
                .CTR_W    (CTR_W),
                .LEN_W    (LEN_W),
                .CTR_INIT (CTR_INIT)
            ) u_ctx (
                .clk          (clk),
                .rst_n        (rst_n),
                .i_load       (w_load),
                .i_iv         (i_iv),
                .i_num_blocks (i_num_blocks),
                .i_adv        (w_adv),
                .o_iv         (w_iv[g]),
                .o_ctr        (w_ctr[g]),
                .o_active     (w_active[g]),
                .o_last       (w_last[g])
            );
        end else begin : g_pad
            assign w_iv[g]     = '0;
            assign w_ctr[g]    = '0;
            assign w_active[g] = 1'b0;
            assign w_last[g]   = 1'b0;
        end
    end

    // The output slot can take a new block when it is empty or being drained.
    assign w_flow      = !r_cb_valid || i_cb_ready;
    // A same-cycle load of the requested channel would race the read, so the
    // request is held off and flagged instead.
    assign w_collide   = i_load && (i_load_ch == i_req_ch);
    // r_rdy_en keeps ready low for the first cycle after reset release.
    assign w_req_ready = r_rdy_en && w_flow && !w_collide;
    assign w_accept    = i_req_valid && w_req_ready;
    assign w_issue     = w_accept && w_active[i_req_ch];
    assign w_reject    = i_req_valid && r_rdy_en && w_flow &&
                         (w_collide || !w_active[i_req_ch]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy_en   <= 1'b0;
            r_j0       <= '0;
            r_j0_valid <= 1'b0;
            r_cb_valid <= 1'b0;
            r_cb       <= '0;
            r_cb_ch    <= '0;
            r_cb_last  <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_rdy_en   <= 1'b1;
            r_j0_valid <= i_load;
            r_err      <= w_reject;
            if (i_load) begin
                r_j0 <= {i_iv, CTR_W'(J0_CTR)};
            end
            if (w_issue) begin
                r_cb_valid <= 1'b1;
                r_cb       <= {w_iv[i_req_ch], w_ctr[i_req_ch]};
                r_cb_ch    <= i_req_ch;
                r_cb_last  <= w_last[i_req_ch];
            end else if (i_cb_ready) begin
                r_cb_valid <= 1'b0;
            end
        end
    end

    assign o_req_ready = w_req_ready;
    assign o_j0        = r_j0;
    assign o_j0_valid  = r_j0_valid;
    assign o_cb_valid  = r_cb_valid;
    assign o_cb        = r_cb;
    assign o_cb_ch     = r_cb_ch;
    assign o_cb_last   = r_cb_last;
    assign o_err       = r_err;

endmodule

// File: tb/tb_gcm_ctr_gen.sv
// -----------------------------------------------------------------------------
// tb_gcm_ctr_gen
// Directed bench for gcm_ctr_gen. A second instance with the first payload
// counter preset to 0xFFFFFFFE shares all inputs and exercises counter wrap.
// -----------------------------------------------------------------------------
module tb_gcm_ctr_gen;

    localparam int NUM_CH = 4;
    localparam int IV_W   = 96;
    localparam int CTR_W  = 32;
    localparam int LEN_W  = 32;
    localparam int BLK    = IV_W + CTR_W;
    localparam int CH_W   = 2;

    localparam logic [IV_W-1:0] IV_A = 96'hCAFEBABE_FACEDBAD_DECAF888;
    localparam logic [IV_W-1:0] IV_B = 96'h11111111_22222222_33333333;
    localparam logic [IV_W-1:0] IV_C = 96'hA5A5A5A5_5A5A5A5A_0F0F0F0F;
    localparam logic [IV_W-1:0] IV_D = 96'h01234567_89ABCDEF_FEDCBA98;
    localparam logic [IV_W-1:0] IV_E = 96'h0000000E_EEEEEEEE_E0000000;
    localparam logic [IV_W-1:0] IV_F = 96'hF00DF00D_BEEFBEEF_12345678;
    localparam logic [IV_W-1:0] IV_G = 96'h76543210_DEADBEEF_C0FFEE00;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic             i_load;
    logic [CH_W-1:0]  i_load_ch;
    logic [IV_W-1:0]  i_iv;
    logic [LEN_W-1:0] i_num_blocks;
    logic             i_req_valid;
    logic [CH_W-1:0]  i_req_ch;
    logic             i_cb_ready;

    logic [BLK-1:0]   o_j0,  w_j0;
    logic             o_j0_valid, w_j0_valid;
    logic             o_req_ready, w_req_ready;
    logic             o_cb_valid, w_cb_valid;
    logic [BLK-1:0]   o_cb,  w_cb;
    logic [CH_W-1:0]  o_cb_ch, w_cb_ch;
    logic             o_cb_last, w_cb_last;
    logic             o_err, w_err;

    gcm_ctr_gen #(
        .NUM_CH (NUM_CH), .IV_W (IV_W), .CTR_W (CTR_W), .LEN_W (LEN_W)
    ) dut (
        .clk (clk), .rst_n (rst_n),
        .i_load (i_load), .i_load_ch (i_load_ch), .i_iv (i_iv), .i_num_blocks (i_num_blocks),
        .o_j0 (o_j0), .o_j0_valid (o_j0_valid),
        .i_req_valid (i_req_valid), .i_req_ch (i_req_ch), .o_req_ready (o_req_ready),
        .o_cb_valid (o_cb_valid), .o_cb (o_cb), .o_cb_ch (o_cb_ch), .o_cb_last (o_cb_last),
        .i_cb_ready (i_cb_ready), .o_err (o_err)
    );

    gcm_ctr_gen #(
        .NUM_CH (NUM_CH), .IV_W (IV_W), .CTR_W (CTR_W), .LEN_W (LEN_W),
        .CTR_INIT (32'hFFFF_FFFE)
    ) dut_wrap (
        .clk (clk), .rst_n (rst_n),
        .i_load (i_load), .i_load_ch (i_load_ch), .i_iv (i_iv), .i_num_blocks (i_num_blocks),
        .o_j0 (w_j0), .o_j0_valid (w_j0_valid),
        .i_req_valid (i_req_valid), .i_req_ch (i_req_ch), .o_req_ready (w_req_ready),
        .o_cb_valid (w_cb_valid), .o_cb (w_cb), .o_cb_ch (w_cb_ch), .o_cb_last (w_cb_last),
        .i_cb_ready (i_cb_ready), .o_err (w_err)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [BLK-1:0] got, input logic [BLK-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [CH_W-1:0] ch, input logic [IV_W-1:0] iv, input logic [LEN_W-1:0] n);
        i_load       = 1'b1;
        i_load_ch    = ch;
        i_iv         = iv;
        i_num_blocks = n;
        tick();
        i_load = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        i_load       = 1'b0;
        i_load_ch    = '0;
        i_iv         = '0;
        i_num_blocks = '0;
        i_req_valid  = 1'b0;
        i_req_ch     = '0;
        i_cb_ready   = 1'b1;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        check("rst_cb_valid", o_cb_valid, 0);
        check("rst_cb",       o_cb,       0);
        check("rst_j0_valid", o_j0_valid, 0);
        check("rst_j0",       o_j0,       0);
        check("rst_err",      o_err,      0);
        check("rst_ready",    o_req_ready, 0);
        rst_n = 1'b1;
        #1;
        check("first_cycle_ready", o_req_ready, 0);
        tick();
        check("ready_after_release", o_req_ready, 1);

        // ---------------- unloaded channel / load collision ----------------
        i_req_valid = 1'b1;
        i_req_ch    = 2'd2;
        tick();
        check("unloaded_err",      o_err,      1);
        check("unloaded_cb_valid", o_cb_valid, 0);
        i_req_valid = 1'b0;
        tick();
        check("err_one_cycle", o_err, 0);

        i_load       = 1'b1;
        i_load_ch    = 2'd1;
        i_iv         = IV_B;
        i_num_blocks = '0;
        i_req_valid  = 1'b1;
        i_req_ch     = 2'd1;
        #1;
        check("collide_ready", o_req_ready, 0);
        tick();
        i_load = 1'b0;
        check("collide_err",      o_err,      1);
        check("collide_cb_valid", o_cb_valid, 0);
        check("collide_j0",       o_j0,       {IV_B, 32'h0000_0001});
        // Channel 1 was loaded with a zero budget, so it stays inactive.
        tick();
        check("zero_len_err",      o_err,      1);
        check("zero_len_cb_valid", o_cb_valid, 0);
        i_req_valid = 1'b0;
        tick();

        // ---------------- basic instance: 3 blocks ----------------
        load(2'd0, IV_A, 32'd3);
        check("j0_valid", o_j0_valid, 1);
        check("j0",       o_j0,       {IV_A, 32'h0000_0001});
        i_req_valid = 1'b1;
        i_req_ch    = 2'd0;
        tick();
        check("j0_valid_one_cycle", o_j0_valid, 0);
        check("blk0",      o_cb,       {IV_A, 32'd2});
        check("blk0_vld",  o_cb_valid, 1);
        check("blk0_ch",   o_cb_ch,    0);
        check("blk0_last", o_cb_last,  0);
        tick();
        check("blk1",      o_cb,       {IV_A, 32'd3});
        check("blk1_last", o_cb_last,  0);
        tick();
        check("blk2",      o_cb,       {IV_A, 32'd4});
        check("blk2_last", o_cb_last,  1);
        tick();
        check("exhausted_err", o_err,      1);
        check("exhausted_vld", o_cb_valid, 0);
        i_req_valid = 1'b0;
        tick();

        // ---------------- counter wrap on preset instance ----------------
        load(2'd3, IV_C, 32'd3);
        check("wrap_j0", w_j0, {IV_C, 32'h0000_0001});
        i_req_valid = 1'b1;
        i_req_ch    = 2'd3;
        tick();
        check("wrap_blk0", w_cb, {IV_C, 32'hFFFF_FFFE});
        check("wrap_ch",   w_cb_ch, 3);
        check("wrap_ref",  o_cb, {IV_C, 32'd2});
        tick();
        check("wrap_blk1", w_cb, {IV_C, 32'hFFFF_FFFF});
        check("wrap_rdy",  w_req_ready, 1);
        tick();
        check("wrap_blk2",  w_cb,       {IV_C, 32'h0000_0000});
        check("wrap_last",  w_cb_last,  1);
        check("wrap_vld",   w_cb_valid, 1);
        check("wrap_noerr", w_err,      0);
        check("wrap_j0v",   w_j0_valid, 0);
        i_req_valid = 1'b0;
        tick();

        // ---------------- backpressure ----------------
        load(2'd0, IV_D, 32'd10);
        i_cb_ready  = 1'b0;
        i_req_valid = 1'b1;
        i_req_ch    = 2'd0;
        tick();
        check("bp_first", o_cb, {IV_D, 32'd2});
        check("bp_ready", o_req_ready, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_cb",    o_cb,        {IV_D, 32'd2});
            check("bp_hold_vld",   o_cb_valid,  1);
            check("bp_hold_ready", o_req_ready, 0);
        end
        i_cb_ready = 1'b1;
        #1;
        check("bp_release_ready", o_req_ready, 1);
        tick();
        check("bp_next0", o_cb, {IV_D, 32'd3});
        tick();
        check("bp_next1", o_cb, {IV_D, 32'd4});
        i_req_valid = 1'b0;
        tick();
        check("drain_vld", o_cb_valid, 0);

        // ---------------- interleaved channels, reload ----------------
        load(2'd1, IV_E, 32'd2);
        load(2'd2, IV_F, 32'd2);
        i_req_valid = 1'b1;
        i_req_ch    = 2'd1;
        tick();
        check("il_blk0",    o_cb,      {IV_E, 32'd2});
        check("il_blk0_ch", o_cb_ch,   1);
        // Loading a different channel alongside the request must not disturb it.
        i_req_ch     = 2'd2;
        i_load       = 1'b1;
        i_load_ch    = 2'd0;
        i_iv         = IV_G;
        i_num_blocks = 32'd1;
        tick();
        i_load = 1'b0;
        check("il_blk1",      o_cb,      {IV_F, 32'd2});
        check("il_blk1_ch",   o_cb_ch,   2);
        check("il_blk1_last", o_cb_last, 0);
        i_req_ch = 2'd1;
        tick();
        check("il_blk2",      o_cb,      {IV_E, 32'd3});
        check("il_blk2_ch",   o_cb_ch,   1);
        check("il_blk2_last", o_cb_last, 1);
        i_req_valid = 1'b0;
        load(2'd2, IV_G, 32'd1);
        i_req_valid = 1'b1;
        i_req_ch    = 2'd2;
        tick();
        check("reload_blk",  o_cb,      {IV_G, 32'd2});
        check("reload_last", o_cb_last, 1);
        i_req_valid = 1'b0;
        tick();

        // ---------------- reset with a pending block ----------------
        load(2'd3, IV_A, 32'd5);
        i_cb_ready  = 1'b0;
        i_req_valid = 1'b1;
        i_req_ch    = 2'd3;
        tick();
        i_req_valid = 1'b0;
        check("pre_rst_ch", o_cb_ch, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_vld",  o_cb_valid, 0);
        check("async_rst_cb",   o_cb,       0);
        check("async_rst_ch",   o_cb_ch,    0);
        check("async_rst_last", o_cb_last,  0);
        check("async_rst_j0",   o_j0,       0);
        i_cb_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("post_rst_first_ready", o_req_ready, 0);
        tick();
        i_req_valid = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            i_req_ch = CH_W'(c);
            tick();
            check("post_rst_err", o_err,      1);
            check("post_rst_vld", o_cb_valid, 0);
        end
        i_req_valid = 1'b0;
        tick();
        check("post_rst_err_clear", o_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
